// File: rtl/sb_tx_pkt_scheduler.sv
// sb_tx_pkt_scheduler
//   Sideband transmit scheduler. Arbitrates round-robin between NUM_SRC
//   message sources, or emits the sideband clock pattern on request, and
//   frames each packet as header word, optional data word and an idle gap.
//
// Optional feature macro: SB_TX_PARITY_EN
//   Defined   -> header bit 62 (DP) and bit 63 (CP) are rewritten at capture.
//   Undefined -> the header is sent unchanged.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_pattern_req    level request for PATTERN_WORDS clock-pattern words
//   i_req            per-source packet request, held until granted
//   i_has_data       per-source: packet carries a data word
//   i_header/i_data  per-source words, source k at [64k+63:64k]
//   i_ser_ready      serializer accepts o_word this cycle
//   o_word           word to serializer
//   o_word_valid     o_word valid
//   o_grant          one-hot, one-cycle pulse when a source is captured
//   o_pattern_done   one-cycle pulse after the last pattern word is accepted
//   o_busy           FSM is not IDLE
//   o_dbg_state      current FSM state (state_e encoding)
//
// Handshake: a word moves when o_word_valid && i_ser_ready at a rising edge;
// while valid is high and ready is low, o_word and o_word_valid hold.
`timescale 1ns/1ps
module sb_tx_pkt_scheduler #(
  parameter int NUM_SRC       = 4,
  parameter int PATTERN_WORDS = 4,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pattern_req,
  input  logic [NUM_SRC-1:0]    i_req,
  input  logic [NUM_SRC-1:0]    i_has_data,
  input  logic [NUM_SRC*64-1:0] i_header,
  input  logic [NUM_SRC*64-1:0] i_data,
  input  logic                  i_ser_ready,
  output logic [63:0]           o_word,
  output logic                  o_word_valid,
  output logic [NUM_SRC-1:0]    o_grant,
  output logic                  o_pattern_done,
  output logic                  o_busy,
  output logic [2:0]            o_dbg_state
);

  localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PAT_W = $clog2(PATTERN_WORDS + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PATTERN_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [63:0] PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PATTERN = 3'd1,
    S_HEADER  = 3'd2,
    S_DATA    = 3'd3,
    S_GAP     = 3'd4
  } state_e;

  state_e             state;
  logic [RR_W-1:0]    rr;
  logic [PAT_W-1:0]   pat_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [63:0]        cap_data;
  logic               cap_has_data;

  logic               win_found;
  logic [RR_W-1:0]    win_idx;
  logic [RR_W-1:0]    cand;
  logic [RR_W-1:0]    rr_next;
  logic [NUM_SRC-1:0] win_onehot;
  logic [63:0]        sel_header;
  logic [63:0]        sel_data;
  logic               sel_has_data;
  logic [63:0]        tx_header;
  logic               accept;

  assign o_dbg_state = state;
  assign accept      = o_word_valid & i_ser_ready;

  // First requester at or after rr, scanning upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = RR_W'((int'(rr) + i) % NUM_SRC);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign rr_next      = (int'(win_idx) == NUM_SRC - 1) ? '0 : win_idx + 1'b1;
  assign sel_header   = i_header[int'(win_idx)*64 +: 64];
  assign sel_data     = i_data[int'(win_idx)*64 +: 64];
  assign sel_has_data = i_has_data[win_idx];

  // Parity is folded into the capture path so it adds no latency.
  always_comb begin
    tx_header = sel_header;
`ifdef SB_TX_PARITY_EN
    tx_header[62] = sel_has_data ? (^sel_data) : 1'b0;
    tx_header[63] = (^sel_header[61:0]) ^ tx_header[62];
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      rr             <= '0;
      pat_cnt        <= '0;
      gap_cnt        <= '0;
      cap_data       <= '0;
      cap_has_data   <= 1'b0;
      o_word         <= '0;
      o_word_valid   <= 1'b0;
      o_grant        <= '0;
      o_pattern_done <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_grant        <= '0;
      o_pattern_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Pattern has priority; a pending i_req stays pending until the next IDLE.
          if (i_pattern_req) begin
            state        <= S_PATTERN;
            pat_cnt      <= '0;
            o_word       <= PATTERN_WORD;
            o_word_valid <= 1'b1;
            o_busy       <= 1'b1;
          end else if (win_found) begin
            state        <= S_HEADER;
            rr           <= rr_next;
            o_grant      <= win_onehot;
            cap_data     <= sel_data;
            cap_has_data <= sel_has_data;
            o_word       <= tx_header;
            o_word_valid <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        S_PATTERN: begin
          if (accept) begin
            pat_cnt <= pat_cnt + 1'b1;
            if (pat_cnt == PAT_LAST) begin
              state          <= S_IDLE;
              o_word_valid   <= 1'b0;
              o_pattern_done <= 1'b1;
              o_busy         <= 1'b0;
            end
          end
        end
        S_HEADER: begin
          if (accept) begin
            if (cap_has_data) begin
              state  <= S_DATA;
              o_word <= cap_data;
            end else begin
              o_word_valid <= 1'b0;
              gap_cnt      <= '0;
              if (GAP_CYCLES == 0) begin
                state  <= S_IDLE;
                o_busy <= 1'b0;
              end else begin
                state <= S_GAP;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            o_word_valid <= 1'b0;
            gap_cnt      <= '0;
            if (GAP_CYCLES == 0) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          o_word_valid <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sb_tx_pkt_scheduler.md
# sb_tx_pkt_scheduler

Parametrised sideband transmit scheduler. It arbitrates between `NUM_SRC` message sources with round-robin priority and emits the sideband clock pattern on request. It frames each packet as a 64-bit header word, an optional 64-bit data word and a mandatory inter-packet gap. It sits between the sideband message encoders and the 64-bit TX serializer, and generalises the single-source sideband TX FSM to multiple sources with a configurable pattern length and gap.

## Interface
Parameters:
- `NUM_SRC`, 4: number of message sources (≥1).
- `PATTERN_WORDS`, 4: 64-bit pattern words per pattern request (≥1).
- `GAP_CYCLES`, 2: idle cycles after every packet (≥0).

Ports:
- `i_clk` in 1: single clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_pattern_req` in 1: level request to send the clock pattern.
- `i_req` in NUM_SRC: per-source packet request; held until granted.
- `i_has_data` in NUM_SRC: source packet carries a data word.
- `i_header` in NUM_SRC*64: headers; source k occupies [64k+63:64k].
- `i_data` in NUM_SRC*64: data words, same packing.
- `i_ser_ready` in 1: serializer accepts `o_word` this cycle.
- `o_word` out 64: word to serializer.
- `o_word_valid` out 1: `o_word` valid.
- `o_grant` out NUM_SRC: one-hot, one-cycle pulse, source payload captured.
- `o_pattern_done` out 1: one-cycle pulse after the last pattern word is accepted.
- `o_busy` out 1: state ≠ IDLE.

## Operation
- States and transitions:
  - IDLE → PATTERN if `i_pattern_req`.
  - IDLE → HEADER if any `i_req` (pattern wins when both are present).
  - PATTERN → IDLE after `PATTERN_WORDS` accepted words.
  - HEADER → DATA on acceptance if the captured has_data bit is 1, else HEADER → GAP.
  - DATA → GAP on acceptance.
  - GAP → IDLE after `GAP_CYCLES` cycles; when `GAP_CYCLES`=0, GAP is skipped and the block goes straight to IDLE.
- Word acceptance means `o_word_valid && i_ser_ready`.
- PATTERN:
  - `o_word`=64'hAAAA_AAAA_AAAA_AAAA, valid held high.
  - Word counter width is $clog2(PATTERN_WORDS+1); it increments on each acceptance.
  - On the last acceptance, pulse `o_pattern_done` in the same cycle the state returns to IDLE.
- Arbitration:
  - Round-robin pointer `rr` (reset 0).
  - The winner is the first requesting index at or after `rr`, modulo `NUM_SRC`.
  - On grant, `rr` ← winner+1 (wraps to 0 past `NUM_SRC`-1).
  - The winner's header, data and has_data are captured into local registers. Source inputs are ignored after capture.
- Requests, pattern requests or `i_req` arriving outside IDLE are not lost. They are evaluated at the next IDLE cycle.
- Reset (at any time, including mid-packet): state IDLE, counters 0, `rr`=0, capture registers 0, all outputs 0. A partially sent packet is abandoned and is not resent.

## Timing
- All outputs are registered.
- Request seen in IDLE at edge N:
  - `o_grant` pulses for cycle N+1.
  - `o_word_valid`=1 with the header from cycle N+1.
- Valid/ready: while valid and not ready, `o_word` and `o_word_valid` hold stable. Each word needs at least one cycle.
- With `i_ser_ready` constantly 1, each packet occupies 1 (IDLE) + 1 (header) + has_data + `GAP_CYCLES` cycles. `o_word_valid`=0 during GAP and IDLE.
- `o_busy` is high from cycle N+1 through the last GAP cycle.

## Configuration
- `SB_TX_PARITY_EN` defined:
  - At capture, header bit 62 (DP) ← XOR of the data word, or 0 if no data.
  - Header bit 63 (CP) ← XOR of header[61:0] and the new DP.
  - Computed in the capture cycle; no extra latency.
- `SB_TX_PARITY_EN` undefined: the header is transmitted unchanged.

## Test plan
- Pattern with `PATTERN_WORDS`=4 and `i_ser_ready`=1 → four AAAA words on consecutive cycles, then an `o_pattern_done` pulse. Repeat with ready toggling every other cycle → still exactly four accepted words.
- Source 2 requests header 64'h1, has_data=1, data 64'h2, `GAP_CYCLES`=2 → grant 4'b0100; words 1 then 2; then 2 valid-low cycles; `o_busy` falls after that.
- All four sources requesting continuously → grants in order 0,1,2,3,0. Then only sources 1 and 3 request, starting after a grant to 1 → next grant is 3.
- `i_pattern_req` and `i_req[0]` asserted together in IDLE → pattern runs first, then source 0 is granted.
- Reset asserted mid-DATA with ready held low → all outputs 0 immediately. After release with no requests, the block stays IDLE and `rr`=0.
- With `SB_TX_PARITY_EN` defined, header 64'h0 and data 64'h1 → transmitted header is 64'hC000_0000_0000_0000. Without the macro → 64'h0.
